reg_write_back: RTL and testbench

Write-back stage and architectural register file, directly downstream of the memory stage. Accepts register-write requests from the memory stage (load results) and from the execute stage (ALU results), commits them in age order through a single write port into a 16-entry register file, and provides two combinational read ports to decode. Also sequences the drain-then-stop behaviour on `do_halt`.

---
 rtl/reg_write_back_if.sv | 33 +++
 rtl/reg_write_back.sv | 145 ++++++++++++++
 tb/tb_reg_write_back.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/reg_write_back_if.sv
// Bus bundle for reg_write_back: two write-request sources, halt request,
// two read ports and status flags.
interface reg_write_back_if #(
  parameter int unsigned WIDTH = 16
);
  logic             mem_wr_en;
  logic [3:0]       mem_wr_addr;
  logic [WIDTH-1:0] mem_wr_data;
  logic             exe_wr_en;
  logic [3:0]       exe_wr_addr;
  logic [WIDTH-1:0] exe_wr_data;
  logic             do_halt;
  logic [3:0]       rd_addr1;
  logic [3:0]       rd_addr2;
  logic [WIDTH-1:0] rd_data1;
  logic [WIDTH-1:0] rd_data2;
  logic             wb_stall;
  logic             halted;

  modport master (
    output mem_wr_en, mem_wr_addr, mem_wr_data,
    output exe_wr_en, exe_wr_addr, exe_wr_data,
    output do_halt, rd_addr1, rd_addr2,
    input  rd_data1, rd_data2, wb_stall, halted
  );

  modport slave (
    input  mem_wr_en, mem_wr_addr, mem_wr_data,
    input  exe_wr_en, exe_wr_addr, exe_wr_data,
    input  do_halt, rd_addr1, rd_addr2,
    output rd_data1, rd_data2, wb_stall, halted
  );
endinterface

// File: rtl/reg_write_back.sv
// Write-back stage + 16-entry register file: age-ordered single-port commit
// with a one-entry pending slot and drain-then-halt sequencing.
// Optional macro WB_BYPASS_EN: read ports forward in-flight writes.
module reg_write_back #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned NREG  = 16
) (
  input  logic            clk,
  input  logic            rst,
  reg_write_back_if.slave wb
);

  typedef enum logic [1:0] {
    S_RUN,
    S_DRAIN,
    S_HALTED
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] regs [NREG];

  logic             pend_v;
  logic [3:0]       pend_a;
  logic [WIDTH-1:0] pend_d;

  logic             pend_v_nxt;
  logic [3:0]       pend_a_nxt;
  logic [WIDTH-1:0] pend_d_nxt;

  logic             wr_en;
  logic [3:0]       wr_a;
  logic [WIDTH-1:0] wr_d;

  logic m_v, e_v, halt_req;
  logic p_keep, m_keep, e_keep, e_use, violation;

  // In HALTED every request input is ignored.
  assign m_v      = wb.mem_wr_en && (state != S_HALTED);
  assign e_v      = wb.exe_wr_en && (state != S_HALTED);
  assign halt_req = wb.do_halt   && (state != S_HALTED);

  // Coalesce: a request is dropped when any younger request hits its address.
  assign p_keep    = pend_v && !(m_v && wb.mem_wr_addr == pend_a)
                            && !(e_v && wb.exe_wr_addr == pend_a);
  assign m_keep    = m_v && !(e_v && wb.exe_wr_addr == wb.mem_wr_addr);
  assign e_keep    = e_v;
  assign violation = p_keep && m_keep && e_keep;
  assign e_use     = e_keep && !violation;

  // Oldest surviving request goes to the array, the next one to the slot.
  always_comb begin
    wr_en      = 1'b0;
    wr_a       = '0;
    wr_d       = '0;
    pend_v_nxt = 1'b0;
    pend_a_nxt = pend_a;
    pend_d_nxt = pend_d;
    if (p_keep) begin
      wr_en = 1'b1;
      wr_a  = pend_a;
      wr_d  = pend_d;
      if (m_keep) begin
        pend_v_nxt = 1'b1;
        pend_a_nxt = wb.mem_wr_addr;
        pend_d_nxt = wb.mem_wr_data;
      end else if (e_use) begin
        pend_v_nxt = 1'b1;
        pend_a_nxt = wb.exe_wr_addr;
        pend_d_nxt = wb.exe_wr_data;
      end
    end else if (m_keep) begin
      wr_en = 1'b1;
      wr_a  = wb.mem_wr_addr;
      wr_d  = wb.mem_wr_data;
      if (e_use) begin
        pend_v_nxt = 1'b1;
        pend_a_nxt = wb.exe_wr_addr;
        pend_d_nxt = wb.exe_wr_data;
      end
    end else if (e_use) begin
      wr_en = 1'b1;
      wr_a  = wb.exe_wr_addr;
      wr_d  = wb.exe_wr_data;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_RUN:    if (halt_req) state_nxt = S_DRAIN;
      S_DRAIN:  if (!pend_v_nxt && !m_v && !e_v) state_nxt = S_HALTED;
      S_HALTED: state_nxt = S_HALTED;
      default:  state_nxt = S_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_RUN;
      pend_v <= 1'b0;
      pend_a <= '0;
      pend_d <= '0;
      for (int unsigned i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      state  <= state_nxt;
      pend_v <= pend_v_nxt;
      pend_a <= pend_a_nxt;
      pend_d <= pend_d_nxt;
      if (wr_en) regs[wr_a] <= wr_d;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    assert (rst || !violation)
      else $error("reg_write_back: three distinct write requests, exe request dropped");
  end
`endif

  logic [3:0]       ra [2];
  logic [WIDTH-1:0] rd [2];

  assign ra[0] = wb.rd_addr1;
  assign ra[1] = wb.rd_addr2;

  always_comb begin
    for (int unsigned i = 0; i < 2; i++) begin
      rd[i] = regs[ra[i]];
`ifdef WB_BYPASS_EN
      if (e_use && wb.exe_wr_addr == ra[i])
        rd[i] = wb.exe_wr_data;
      else if (m_v && wb.mem_wr_addr == ra[i])
        rd[i] = wb.mem_wr_data;
      else if (pend_v && pend_a == ra[i])
        rd[i] = pend_d;
`endif
    end
  end

  assign wb.rd_data1 = rd[0];
  assign wb.rd_data2 = rd[1];
  assign wb.wb_stall = pend_v;
  assign wb.halted   = (state == S_HALTED);

endmodule

// File: tb/tb_reg_write_back.sv
// Directed-vector bench for reg_write_back; expectations depend on whether
// WB_BYPASS_EN is defined for the build.
module tb_reg_write_back;

  logic clk = 1'b0;
  logic rst;
  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  always #5 clk = ~clk;

  reg_write_back_if #(.WIDTH(16)) bus ();

  reg_write_back #(.WIDTH(16), .NREG(16)) dut (
    .clk (clk),
    .rst (rst),
    .wb  (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.mem_wr_en   = 1'b0;
    bus.mem_wr_addr = '0;
    bus.mem_wr_data = '0;
    bus.exe_wr_en   = 1'b0;
    bus.exe_wr_addr = '0;
    bus.exe_wr_data = '0;
    bus.do_halt     = 1'b0;
  endtask

  task automatic mem_wr(input logic [3:0] a, input logic [15:0] d);
    bus.mem_wr_en   = 1'b1;
    bus.mem_wr_addr = a;
    bus.mem_wr_data = d;
  endtask

  task automatic exe_wr(input logic [3:0] a, input logic [15:0] d);
    bus.exe_wr_en   = 1'b1;
    bus.exe_wr_addr = a;
    bus.exe_wr_data = d;
  endtask

  // Expected same-cycle read of an in-flight value: forwarded or old.
  function automatic logic [15:0] fwd(input logic [15:0] newv, input logic [15:0] oldv);
`ifdef WB_BYPASS_EN
    return newv;
`else
    return oldv;
`endif
  endfunction

  initial begin
    rst = 1'b1;
    idle();
    bus.rd_addr1 = '0;
    bus.rd_addr2 = '0;
    tick();
    tick();
    rst = 1'b0;
    #1;

    // Reset state
    for (int i = 0; i < 16; i++) begin
      bus.rd_addr1 = 4'(i);
      bus.rd_addr2 = 4'(15 - i);
      #1;
      check($sformatf("rst_rd1_r%0d", i), bus.rd_data1, 16'h0);
      check($sformatf("rst_rd2_r%0d", 15 - i), bus.rd_data2, 16'h0);
    end
    check("rst_stall", bus.wb_stall, 1'b0);
    check("rst_halted", bus.halted, 1'b0);

    // Same-cycle mem r3 / exe r5: exe deferred one cycle
    mem_wr(4'd3, 16'h7530);
    exe_wr(4'd5, 16'd10);
    #1;
    check("defer_pre_stall", bus.wb_stall, 1'b0);
    tick();
    idle();
    bus.rd_addr1 = 4'd3;
    bus.rd_addr2 = 4'd5;
    #1;
    check("defer_r3", bus.rd_data1, 16'h7530);
    check("defer_stall", bus.wb_stall, 1'b1);
    check("defer_r5_pend", bus.rd_data2, fwd(16'd10, 16'd0));
    tick();
    check("defer_r5", bus.rd_data2, 16'd10);
    check("defer_stall_clr", bus.wb_stall, 1'b0);

    // Same address from both sources: exe wins, no stall
    mem_wr(4'd4, 16'd1);
    exe_wr(4'd4, 16'd2);
    bus.rd_addr1 = 4'd4;
    #1;
    check("coal_r4_pre", bus.rd_data1, fwd(16'd2, 16'd0));
    tick();
    idle();
    #1;
    check("coal_r4", bus.rd_data1, 16'd2);
    check("coal_stall", bus.wb_stall, 1'b0);

    // Read visibility of a fresh exe write
    exe_wr(4'd7, 16'h1234);
    bus.rd_addr1 = 4'd7;
    #1;
    check("vis_r7_same", bus.rd_data1, fwd(16'h1234, 16'h0));
    tick();
    idle();
    #1;
    check("vis_r7_next", bus.rd_data1, 16'h1234);

    // Pending entry overwritten by a younger mem write to the same register
    mem_wr(4'd11, 16'd1);
    exe_wr(4'd12, 16'd2);
    tick();
    idle();
    mem_wr(4'd12, 16'd3);
    bus.rd_addr1 = 4'd12;
    bus.rd_addr2 = 4'd11;
    #1;
    check("pcoal_stall", bus.wb_stall, 1'b1);
    check("pcoal_r12_pre", bus.rd_data1, fwd(16'd3, 16'd0));
    tick();
    idle();
    #1;
    check("pcoal_r12", bus.rd_data1, 16'd3);
    check("pcoal_r11", bus.rd_data2, 16'd1);
    check("pcoal_stall_clr", bus.wb_stall, 1'b0);
    tick();
    check("pcoal_r12_hold", bus.rd_data1, 16'd3);

    // Asynchronous reset while pending holds r6=5
    mem_wr(4'd2, 16'h22);
    exe_wr(4'd6, 16'd5);
    tick();
    idle();
    #1;
    check("rstmid_stall_pre", bus.wb_stall, 1'b1);
    rst = 1'b1;
    bus.rd_addr1 = 4'd6;
    bus.rd_addr2 = 4'd2;
    #1;
    check("rstmid_stall", bus.wb_stall, 1'b0);
    check("rstmid_r6", bus.rd_data1, 16'h0);
    check("rstmid_r2", bus.rd_data2, 16'h0);
    tick();
    rst = 1'b0;
    tick();
    check("rstmid_r6_after", bus.rd_data1, 16'h0);
    check("rstmid_stall_after", bus.wb_stall, 1'b0);
    check("rstmid_halted", bus.halted, 1'b0);
    mem_wr(4'd9, 16'h99);
    bus.rd_addr1 = 4'd9;
    tick();
    idle();
    #1;
    check("rstmid_run_r9", bus.rd_data1, 16'h99);

    // Drain then halt with a deferred exe r5 pending
    mem_wr(4'd10, 16'hAAAA);
    exe_wr(4'd5, 16'h55);
    tick();
    idle();
    bus.do_halt  = 1'b1;
    bus.rd_addr1 = 4'd5;
    bus.rd_addr2 = 4'd10;
    #1;
    check("halt_stall", bus.wb_stall, 1'b1);
    check("halt_r10", bus.rd_data2, 16'hAAAA);
    check("halt_h0", bus.halted, 1'b0);
    tick();
    bus.do_halt = 1'b0;
    #1;
    check("halt_r5", bus.rd_data1, 16'h55);
    check("halt_h1", bus.halted, 1'b0);
    check("halt_stall_clr", bus.wb_stall, 1'b0);
    tick();
    check("halt_h2", bus.halted, 1'b1);

    // Frozen: writes ignored, not forwarded either
    mem_wr(4'd1, 16'd9);
    exe_wr(4'd5, 16'hBEEF);
    bus.do_halt  = 1'b1;
    bus.rd_addr1 = 4'd1;
    bus.rd_addr2 = 4'd5;
    #1;
    check("frz_r1_same", bus.rd_data1, 16'h0);
    check("frz_r5_same", bus.rd_data2, 16'h55);
    tick();
    idle();
    #1;
    check("frz_r1", bus.rd_data1, 16'h0);
    check("frz_r5", bus.rd_data2, 16'h55);
    check("frz_halted", bus.halted, 1'b1);
    check("frz_stall", bus.wb_stall, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
